// File: rtl/l2_map_reader.sv
// Streams the six pooled 14x14 L2 maps in column-major order as one 6-channel beat per cycle.
// Optional build macro L2_READ_RELU_EN clamps negative values to zero at FIFO capture.
module l2_map_reader #(
  parameter int DATA_WIDTH = 12,
  parameter int MAP_WIDTH  = 14,
  parameter int MAP_HEIGTH = 14,
  parameter int ADDR_WIDTH = 8,
  parameter int MAP_SIZE   = MAP_WIDTH * MAP_HEIGTH,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  L2_rd_en,
  output logic [ADDR_WIDTH-1:0] L2_out_addr_read,
  input  logic [DATA_WIDTH-1:0] L2_out1_dout,
  input  logic [DATA_WIDTH-1:0] L2_out2_dout,
  input  logic [DATA_WIDTH-1:0] L2_out3_dout,
  input  logic [DATA_WIDTH-1:0] L2_out4_dout,
  input  logic [DATA_WIDTH-1:0] L2_out5_dout,
  input  logic [DATA_WIDTH-1:0] L2_out6_dout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data1,
  output logic [DATA_WIDTH-1:0] out_data2,
  output logic [DATA_WIDTH-1:0] out_data3,
  output logic [DATA_WIDTH-1:0] out_data4,
  output logic [DATA_WIDTH-1:0] out_data5,
  output logic [DATA_WIDTH-1:0] out_data6,
  output logic [3:0]            out_row,
  output logic [3:0]            out_col,
  output logic                  out_last,
  output logic                  rd_done,
  output logic [3:0]            st
);

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    READ  = 4'b0010,
    DRAIN = 4'b0100,
    DONE  = 4'b1000
  } state_t;

  typedef struct packed {
    logic [5:0][DATA_WIDTH-1:0] d;
    logic [3:0]                 row;
    logic [3:0]                 col;
    logic                       last;
  } beat_t;

  localparam logic [2:0]            LP_DEPTH    = 3'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LP_LAST_ADR = ADDR_WIDTH'(MAP_SIZE - 1);
  localparam logic [3:0]            LP_LAST_ROW = 4'(MAP_HEIGTH - 1);

  state_t                r_st;
  state_t                w_st_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [3:0]            r_row;
  logic [3:0]            r_col;
  logic                  r_inflight;
  logic [3:0]            r_if_row;
  logic [3:0]            r_if_col;
  logic                  r_if_last;

  beat_t                 r_fifo [FIFO_DEPTH];
  logic                  r_wp;
  logic                  r_rp;
  logic [1:0]            r_cnt;

  logic                  w_pop;
  logic                  w_push;
  logic [2:0]            w_occ;
  logic                  w_issue;
  logic                  w_last_adr;
  logic [5:0][DATA_WIDTH-1:0] w_raw;
  beat_t                 w_cap;
  beat_t                 w_out;

  assign out_valid  = (r_cnt != 2'd0);
  assign w_pop      = out_valid && out_ready;
  assign w_push     = r_inflight;
  // Occupancy seen by the issue logic counts the read in flight and frees the slot popped this cycle.
  assign w_occ      = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_last_adr = (r_addr == LP_LAST_ADR);
  assign w_issue    = (r_st == READ) && L2_rd_en && (w_occ < LP_DEPTH);

`ifdef L2_READ_RELU_EN
  function automatic logic [DATA_WIDTH-1:0] f_relu(input logic [DATA_WIDTH-1:0] v);
    return v[DATA_WIDTH-1] ? '0 : v;
  endfunction
`endif

  assign w_raw = {L2_out6_dout, L2_out5_dout, L2_out4_dout,
                  L2_out3_dout, L2_out2_dout, L2_out1_dout};

  always_comb begin
    w_cap      = '0;
    w_cap.row  = r_if_row;
    w_cap.col  = r_if_col;
    w_cap.last = r_if_last;
    for (int unsigned i = 0; i < 6; i++) begin
`ifdef L2_READ_RELU_EN
      w_cap.d[i] = f_relu(w_raw[i]);
`else
      w_cap.d[i] = w_raw[i];
`endif
    end
  end

  always_comb begin
    w_st_nxt = r_st;
    unique case (r_st)
      IDLE:    if (L2_rd_en) w_st_nxt = READ;
      READ:    if (w_issue && w_last_adr) w_st_nxt = DRAIN;
      DRAIN:   if ((r_cnt == 2'd0) && !r_inflight) w_st_nxt = DONE;
      DONE:    w_st_nxt = DONE;
      default: w_st_nxt = IDLE;
    endcase
    if (!L2_rd_en) w_st_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_st <= IDLE;
    else      r_st <= w_st_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr     <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_inflight <= 1'b0;
      r_if_row   <= '0;
      r_if_col   <= '0;
      r_if_last  <= 1'b0;
      r_wp       <= 1'b0;
      r_rp       <= 1'b0;
      r_cnt      <= '0;
    end else if (!L2_rd_en) begin
      r_addr     <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_inflight <= 1'b0;
      r_if_last  <= 1'b0;
      r_wp       <= 1'b0;
      r_rp       <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_if_row  <= r_row;
        r_if_col  <= r_col;
        r_if_last <= w_last_adr;
        // The counters park on the final address so it never runs past the map.
        if (!w_last_adr) begin
          r_addr <= r_addr + 1'b1;
          if (r_row == LP_LAST_ROW) begin
            r_row <= '0;
            r_col <= r_col + 1'b1;
          end else begin
            r_row <= r_row + 1'b1;
          end
        end
      end
      if (w_push) r_wp <= ~r_wp;
      if (w_pop)  r_rp <= ~r_rp;
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wp] <= w_cap;
  end

  assign w_out = out_valid ? r_fifo[r_rp] : '0;

  assign L2_out_addr_read = r_addr;
  assign out_data1        = w_out.d[0];
  assign out_data2        = w_out.d[1];
  assign out_data3        = w_out.d[2];
  assign out_data4        = w_out.d[3];
  assign out_data5        = w_out.d[4];
  assign out_data6        = w_out.d[5];
  assign out_row          = w_out.row;
  assign out_col          = w_out.col;
  assign out_last         = w_out.last;
  assign rd_done          = (r_st == DONE);
  assign st               = r_st;

endmodule

// File: tb/tb_l2_map_reader.sv
// Scoreboard bench for l2_map_reader: stimulus queues expected beats, a negedge monitor checks accepted beats.
module tb_l2_map_reader;
  localparam int DW = 12;
  localparam int AW = 8;
  localparam int NB = 196;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          L2_rd_en = 1'b0;
  logic          out_ready = 1'b0;
  logic [AW-1:0] addr;
  logic [DW-1:0] dout [6];
  logic          out_valid, out_last, rd_done;
  logic [DW-1:0] od1, od2, od3, od4, od5, od6;
  logic [3:0]    out_row, out_col, st;

  typedef struct packed {
    logic [5:0][DW-1:0] d;
    logic [3:0]         row;
    logic [3:0]         col;
    logic               last;
  } beat_t;

  logic [DW-1:0] mem [6][NB];
  beat_t         exp_q [$];
  beat_t         held;
  beat_t         got;
  bit            hold_pend = 0;
  bit            chk_lead = 0;
  int            n_cmp = 0, n_err = 0, n_acc = 0, cyc = 0;
  int            last_cyc = -1, done_cyc = -1;
  int            acc_cyc [3];
  logic [DW-1:0] b7_d3, b8_d3;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    for (int c = 0; c < 6; c++) dout[c] <= (addr < AW'(NB)) ? mem[c][addr] : '0;
  end

  l2_map_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .L2_rd_en(L2_rd_en), .L2_out_addr_read(addr),
    .L2_out1_dout(dout[0]), .L2_out2_dout(dout[1]), .L2_out3_dout(dout[2]),
    .L2_out4_dout(dout[3]), .L2_out5_dout(dout[4]), .L2_out6_dout(dout[5]),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data1(od1), .out_data2(od2), .out_data3(od3),
    .out_data4(od4), .out_data5(od5), .out_data6(od6),
    .out_row(out_row), .out_col(out_col), .out_last(out_last),
    .rd_done(rd_done), .st(st)
  );

  assign got = {od6, od5, od4, od3, od2, od1, out_row, out_col, out_last};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_val(input int ch, input int k);
    logic [DW-1:0] v;
    v = mem[ch][k];
`ifdef L2_READ_RELU_EN
    if (v[DW-1]) v = '0;
`endif
    return v;
  endfunction

  task automatic push_beats(input int n);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < 6; c++) b.d[c] = exp_val(c, k);
      b.row  = 4'(k % 14);
      b.col  = 4'(k / 14);
      b.last = (k == NB - 1);
      exp_q.push_back(b);
    end
  endtask

  // Monitor: scoreboard pop on accept, stall stability, issue lead bound.
  always @(negedge clk) begin
    if (rst) begin
      if (chk_lead) begin
        n_cmp++;
        if (int'(addr) > n_acc + 2) begin
          n_err++;
          $display("FAIL addr_lead: got addr %0d accepted %0d required at most %0d", addr, n_acc, n_acc + 2);
        end
      end
      if (hold_pend && out_valid) begin
        n_cmp++;
        if (got !== held) begin
          n_err++;
          $display("FAIL stall_stable: got %h required %h", got, held);
        end
      end
      hold_pend = 0;
      if (out_valid && !out_ready) begin
        held = got;
        hold_pend = 1;
      end
      if (out_valid && out_ready) begin
        beat_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL beat_unexpected: got row %0d col %0d d1 %h required no beat", out_row, out_col, od1);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            n_err++;
            $display("FAIL beat%0d: got d=%h r=%0d c=%0d l=%0b required d=%h r=%0d c=%0d l=%0b",
                     n_acc, got.d, got.row, got.col, got.last, e.d, e.row, e.col, e.last);
          end
        end
        if (n_acc < 3) acc_cyc[n_acc] = cyc;
        if (n_acc == 7) b7_d3 = od3;
        if (n_acc == 8) b8_d3 = od3;
        if (out_last) last_cyc = cyc;
        n_acc++;
      end
    end
  end

  task automatic run_to_done(input bit toggle);
    bit seen = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (toggle) out_ready = ((i % 4) == 0) || ((i % 4) == 3);
      if (rd_done) begin
        seen = 1;
        done_cyc = cyc;
        break;
      end
    end
    check("rd_done_reached", 32'(seen), 32'd1);
  endtask

  task automatic end_pass(input string tag);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    L2_rd_en = 1'b0;
    @(posedge clk); #1;
    check({tag, "_idle_st"}, 32'(st), 32'h1);
    check({tag, "_idle_done"}, 32'(rd_done), 0);
    @(posedge clk); #1;
  endtask

  task automatic start_pass(input int n, input logic rdy);
    n_acc = 0;
    last_cyc = -1;
    push_beats(n);
    out_ready = rdy;
    L2_rd_en = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int c = 0; c < 6; c++)
      for (int a = 0; a < NB; a++) mem[c][a] = DW'(a + 16 * c);

    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_st", 32'(st), 32'h1);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_addr", 32'(addr), 0);
    check("rst_done", 32'(rd_done), 0);
    check("rst_last", 32'(out_last), 0);
    check("rst_data1", 32'(od1), 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Pass A: free-flowing, latency, throughput and done timing.
    start_pass(NB, 1'b1);
    @(posedge clk); #1;
    check("lat_st_read", 32'(st), 32'h2);
    check("lat_valid_c0", 32'(out_valid), 0);
    check("lat_addr_c0", 32'(addr), 0);
    @(posedge clk); #1;
    check("lat_valid_c1", 32'(out_valid), 0);
    @(posedge clk); #1;
    check("lat_valid_c2", 32'(out_valid), 1);
    run_to_done(1'b0);
    check("done_after_last", done_cyc - last_cyc, 2);
    check("throughput_span", last_cyc - acc_cyc[0], 195);
    check("final_addr", 32'(addr), 195);
    end_pass("A");

    // Pass B: out_ready 1,0,0,1 repeating.
    start_pass(NB, 1'b1);
    chk_lead = 1;
    run_to_done(1'b1);
    chk_lead = 0;
    out_ready = 1'b1;
    end_pass("B");

    // Pass C: held off for 20 cycles at start.
    start_pass(NB, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    check("stall_addr", 32'(addr), 2);
    check("stall_valid", 32'(out_valid), 1);
    check("stall_head_row", 32'(out_row), 0);
    out_ready = 1'b1;
    run_to_done(1'b0);
    check("release_b1_gap", acc_cyc[1] - acc_cyc[0], 1);
    check("release_b2_gap", acc_cyc[2] - acc_cyc[1], 1);
    end_pass("C");

    // Pass D: abort after beat 50, then restart.
    start_pass(51, 1'b1);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (n_acc >= 51) break;
    end
    check("abort_accepted", n_acc, 51);
    L2_rd_en = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    check("abort_st", 32'(st), 32'h1);
    check("abort_valid", 32'(out_valid), 0);
    check("abort_queue_empty", exp_q.size(), 0);
    @(posedge clk); #1;
    start_pass(NB, 1'b1);
    run_to_done(1'b0);
    end_pass("D");

    // Pass E: asynchronous reset mid-read.
    start_pass(NB, 1'b1);
    repeat (30) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 0);
    check("arst_addr", 32'(addr), 0);
    check("arst_st", 32'(st), 32'h1);
    check("arst_row", 32'(out_row), 0);
    exp_q.delete();
    n_acc = 0;
    push_beats(NB);
    @(posedge clk);
    #3 rst = 1'b1;
    run_to_done(1'b0);
    end_pass("E");

    // Pass F: sign handling of channel 3.
    mem[2][7] = 12'hF80;
    mem[2][8] = 12'h07F;
    start_pass(NB, 1'b1);
    run_to_done(1'b0);
`ifdef L2_READ_RELU_EN
    check("relu_b7_d3", 32'(b7_d3), 32'h000);
`else
    check("raw_b7_d3", 32'(b7_d3), 32'hF80);
`endif
    check("b8_d3", 32'(b8_d3), 32'h07F);
    end_pass("F");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/l2_map_reader.md
Name: l2_map_reader

Overview:
- Consumer-side reader for the six pooled L2 output block memories that the layer-1 conv/pool path fills.
- Walks the 14x14 maps in the same column-major order the writer produces: row inner, column outer, linear address 0..195.
- Presents one 6-channel pixel per beat on a valid/ready stream to the layer-3 convolution front end.
- Absorbs the 1-cycle BRAM read latency and downstream backpressure with a 2-entry output FIFO.

Parameters:
- DATA_WIDTH, 12, width of one pooled value (two's complement).
- MAP_WIDTH, 14, pooled map columns.
- MAP_HEIGTH, 14, pooled map rows.
- ADDR_WIDTH, 8, L2 memory address width.
- MAP_SIZE, MAP_WIDTH*MAP_HEIGTH (196), entries per map.
- FIFO_DEPTH, 2, output buffer entries; fixed at 2 (credit logic sized for it).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- L2_rd_en  in  1  level enable; start reading when high, abort when low.
- L2_out_addr_read  out  ADDR_WIDTH  shared read address to all six L2 memories.
- L2_out1_dout..L2_out6_dout  in  DATA_WIDTH each  BRAM read data, valid 1 cycle after address.
- out_valid  out  1  stream beat valid.
- out_ready  in  1  downstream accept.
- out_data1..out_data6  out  DATA_WIDTH each  channel values of current beat.
- out_row  out  4  row (0..13) of current beat.
- out_col  out  4  column (0..13) of current beat.
- out_last  out  1  high on beat row=13, col=13.
- rd_done  out  1  high while in DONE.
- st  out  4  one-hot state, for debug.

Behaviour:
- States, one-hot: IDLE=4'b0001, READ=4'b0010, DRAIN=4'b0100, DONE=4'b1000.
- Reset (rst=0, asynchronous):
  - st=IDLE; FIFO empty; address counter, row and col counters = 0; in-flight flag = 0.
  - Outputs: out_valid=0, out_last=0, rd_done=0, L2_out_addr_read=0, out_data*/out_row/out_col=0.
- Transitions:
  - IDLE -> READ when L2_rd_en=1.
  - READ -> DRAIN after the read of address MAP_SIZE-1 issues.
  - DRAIN -> DONE when the FIFO is empty and nothing is in flight.
  - DONE holds while L2_rd_en=1.
  - Any state -> IDLE in the cycle after L2_rd_en=0. This flushes the FIFO, clears counters and drops the in-flight read.
- Read issue:
  - In READ, a read issues in a cycle when (FIFO occupancy + in-flight + 0) < FIFO_DEPTH, counting a same-cycle pop as freeing a slot.
  - Issue means: address counter drives L2_out_addr_read; in-flight set for one cycle; counter increments; row increments, wrapping 13->0 with col+1.
  - Without an issue, the address holds.
- Capture: in-flight data (all six douts plus the row/col/last tag) is written into the FIFO on the next edge.
- Output:
  - out_* reflect the FIFO head; out_valid = FIFO non-empty.
  - Pop when out_valid && out_ready.
  - Push and pop in the same cycle keep occupancy unchanged.
- Latency: the first READ cycle issues address 0; out_valid rises 2 cycles after st becomes READ.
- Throughput: with out_ready held high, 1 beat per cycle and 196 beats in 197 cycles from the first issue.
- Beats are never dropped or duplicated under any out_ready pattern. While out_valid=1 and out_ready=0, out_data*/out_row/out_col/out_last hold stable.
- Arithmetic: data passes unmodified except under the optional feature. Address never exceeds MAP_SIZE-1.
- L2_rd_en re-asserted from DONE after a drop restarts at address 0.

Optional Feature:
- L2_READ_RELU_EN
- Defined: each out_dataN is clamped to 0 when its MSB is 1 (negative two's complement); non-negative values pass unchanged. The clamp is applied at FIFO capture, so latency is unchanged.
- Undefined: raw values pass through, and no clamp logic is instantiated.

Test Plan:
- Memories preloaded with value = address+16*channel, out_ready=1, L2_rd_en=1:
  - Beat k carries out_data1=k, out_data6=k+80, out_row=k%14, out_col=k/14.
  - out_last only on k=195.
  - First out_valid 2 cycles after READ entry.
  - rd_done asserts 2 cycles after the last beat.
- out_ready toggling 1,0,0,1 repeating: all 196 beats arrive in order, no gaps or duplicates; data stable during stalls; L2_out_addr_read never more than 2 ahead of the accepted count.
- out_ready=0 for 20 cycles right after start: exactly 2 reads issue (addresses 0 and 1) and the address holds at 2. On release, beats 0,1,2 follow back to back.
- L2_rd_en dropped after beat 50 is accepted: next cycle st=IDLE, out_valid=0. Re-enable restarts with beat 0 (row 0, col 0).
- rst pulsed low mid-READ, asynchronously between edges: outputs go immediately to reset values; with L2_rd_en still high, the reader restarts from address 0 after release.
- With L2_READ_RELU_EN and memory word 12'hF80 at address 7, channel 3: beat 7 out_data3=0. Word 12'h07F passes as 12'h07F. Without the macro, 12'hF80 passes unchanged.
